// File: rtl/serial_shift_reg_pkg.sv
// serial_shift_reg_pkg: shared constants and types for the serial shift register.
// Direction enum is only referenced when SERIAL_SHIFT_REG_BIDIR_EN is defined.
package serial_shift_reg_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH = 64;

    // Reset word, sliced down to the instance width by the user.
    localparam logic [MAX_WIDTH-1:0] RESET_WORD = '0;

    typedef enum logic {
        SHIFT_RIGHT = 1'b0,
        SHIFT_LEFT  = 1'b1
    } shift_dir_e;

endpackage

// File: rtl/serial_shift_reg_stage.sv
// serial_shift_reg_stage: one D flip-flop of the shift chain.
// Asynchronous active-high clear forces the stage to its reset value.
module serial_shift_reg_stage
    import serial_shift_reg_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic clear,
    input  logic d,
    output logic q
);

    // Capture d on every rising edge unless held in clear.
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            q <= RST_VAL;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: serial-in/serial-out shift register with parallel tap.
// Define SERIAL_SHIFT_REG_BIDIR_EN to add a dir input for left shifting.
module serial_shift_reg
    import serial_shift_reg_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             SI,
`ifdef SERIAL_SHIFT_REG_BIDIR_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             SO
);

    localparam logic [WIDTH-1:0] RST = RESET_WORD[WIDTH-1:0];

    if (WIDTH < 2 || WIDTH > MAX_WIDTH) begin : g_bad_width
        $error("serial_shift_reg: WIDTH must be 2..64");
    end

    logic [WIDTH-1:0] d;

`ifdef SERIAL_SHIFT_REG_BIDIR_EN
    // Next-stage inputs: SI enters at the top (right) or bottom (left).
    always_comb begin
        d = {SI, Q[WIDTH-1:1]};
        if (shift_dir_e'(dir) == SHIFT_LEFT) begin
            d = {Q[WIDTH-2:0], SI};
        end
    end

    // Serial output is the stage that falls off the far end.
    always_comb begin
        SO = Q[0];
        if (shift_dir_e'(dir) == SHIFT_LEFT) begin
            SO = Q[WIDTH-1];
        end
    end
`else
    // Next-stage inputs: SI enters at the top, word moves toward bit 0.
    always_comb begin
        d = {SI, Q[WIDTH-1:1]};
    end

    // Serial output is the oldest bit.
    always_comb begin
        SO = Q[0];
    end
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        serial_shift_reg_stage #(
            .RST_VAL (RST[i])
        ) u_stage (
            .clk   (clk),
            .clear (clear),
            .d     (d[i]),
            .q     (Q[i])
        );
    end

endmodule

// File: tb/tb_serial_shift_reg.sv
// tb_serial_shift_reg: directed self-checking bench for serial_shift_reg.
// Build with SERIAL_SHIFT_REG_BIDIR_EN to include the left-shift scenario.
module tb_serial_shift_reg;

    localparam int W = 4;

    logic         clk;
    logic         clear;
    logic         SI;
    logic [W-1:0] Q;
    logic         SO;
`ifdef SERIAL_SHIFT_REG_BIDIR_EN
    logic         dir;
`endif

    int errors;
    int checks;

    serial_shift_reg #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .SI    (SI),
`ifdef SERIAL_SHIFT_REG_BIDIR_EN
        .dir   (dir),
`endif
        .Q     (Q),
        .SO    (SO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present b, take one rising edge, then settle 1ns past it.
    task automatic tick(input logic b);
        SI = b;
        @(posedge clk);
        #1;
    endtask

    // Clear pulse placed between edges; leaves register at zero.
    task automatic pulse_clear();
        @(posedge clk);
        #2;
        clear = 1'b1;
        #2;
        clear = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        SI = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (Q !== 4'b0000 || SO !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: Q=%b SO=%b expected Q=0000 SO=0", Q, SO);
        end
        clear = 1'b0;
        tick(1'b1);
        tick(1'b1);
        checks++;
        if (Q !== 4'b1100) begin
            errors++;
            $display("FAIL reset_preload: Q=%b expected 1100", Q);
        end
        #2;
        clear = 1'b1;
        #1;
        checks++;
        if (Q !== 4'b0000 || SO !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: Q=%b SO=%b expected Q=0000 SO=0", Q, SO);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1);
            checks++;
            if (Q !== 4'b0000 || SO !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold%0d: Q=%b SO=%b expected Q=0000 SO=0", i, Q, SO);
            end
        end
        clear = 1'b0;
        SI = 1'b0;
    endtask

    task automatic test_walking_one();
        logic [W-1:0] exp_q [5];
        logic         exp_so [5];
        exp_q  = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0000};
        exp_so = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        pulse_clear();
        for (int i = 0; i < 5; i++) begin
            tick(i == 0);
            checks++;
            if (Q !== exp_q[i] || SO !== exp_so[i]) begin
                errors++;
                $display("FAIL walk_edge%0d: Q=%b SO=%b expected Q=%b SO=%b",
                         i + 1, Q, SO, exp_q[i], exp_so[i]);
            end
        end
    endtask

    task automatic test_stream();
        logic [3:0] bits;
        logic       exp_so [4];
        bits   = 4'b1011;
        exp_so = '{1'b1, 1'b0, 1'b1, 1'b1};
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            tick(bits[3-i]);
        end
        checks++;
        if (Q !== 4'b1101) begin
            errors++;
            $display("FAIL stream_q: Q=%b expected 1101", Q);
        end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) tick(1'b0);
            checks++;
            if (SO !== exp_so[i]) begin
                errors++;
                $display("FAIL stream_so%0d: SO=%b expected %b", i, SO, exp_so[i]);
            end
        end
    endtask

    task automatic test_ones_zeros();
        pulse_clear();
        for (int i = 0; i < 4; i++) tick(1'b1);
        checks++;
        if (Q !== 4'b1111 || SO !== 1'b1) begin
            errors++;
            $display("FAIL ones_q: Q=%b SO=%b expected Q=1111 SO=1", Q, SO);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0);
            checks++;
            if (SO !== (i < 3)) begin
                errors++;
                $display("FAIL zeros_so%0d: SO=%b expected %b", i + 1, SO, i < 3);
            end
        end
        checks++;
        if (Q !== 4'b0000) begin
            errors++;
            $display("FAIL zeros_q: Q=%b expected 0000", Q);
        end
    endtask

    task automatic test_mid_clear();
        pulse_clear();
        tick(1'b0);
        tick(1'b1);
        tick(1'b0);
        tick(1'b1);
        checks++;
        if (Q !== 4'b1010) begin
            errors++;
            $display("FAIL midclr_load: Q=%b expected 1010", Q);
        end
        #2;
        clear = 1'b1;
        #1;
        checks++;
        if (Q !== 4'b0000 || SO !== 1'b0) begin
            errors++;
            $display("FAIL midclr_async: Q=%b SO=%b expected Q=0000 SO=0", Q, SO);
        end
        clear = 1'b0;
        tick(1'b1);
        checks++;
        if (Q !== 4'b1000) begin
            errors++;
            $display("FAIL midclr_refill: Q=%b expected 1000", Q);
        end
        SI = 1'b0;
    endtask

`ifdef SERIAL_SHIFT_REG_BIDIR_EN
    task automatic test_left();
        logic [W-1:0] exp_q [4];
        exp_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        dir = 1'b1;
        pulse_clear();
        for (int i = 0; i < 4; i++) begin
            tick(i == 0);
            checks++;
            if (Q !== exp_q[i] || SO !== (i == 3)) begin
                errors++;
                $display("FAIL left_edge%0d: Q=%b SO=%b expected Q=%b SO=%b",
                         i + 1, Q, SO, exp_q[i], i == 3);
            end
        end
        dir = 1'b0;
    endtask
`endif

    initial begin
        errors = 0;
        checks = 0;
        clear = 1'b1;
        SI = 1'b0;
`ifdef SERIAL_SHIFT_REG_BIDIR_EN
        dir = 1'b0;
`endif
        test_reset();
        test_walking_one();
        test_stream();
        test_ones_zeros();
        test_mid_clear();
`ifdef SERIAL_SHIFT_REG_BIDIR_EN
        test_left();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
